esc_output_controller: RTL and testbench

- Parametrised N-motor ESC output stage with arming and failsafe. It replaces the fixed 4-channel path from motor mixer rates to PWM.
- Takes packed motor rates plus a valid strobe from the motor mixer, then produces one ESC pulse per motor per frame. Pulse updates happen only at frame boundaries.
- Adds an arming sequence, per-frame slew limiting and a failsafe on a stale-data timeout.
- Runs entirely on sys_clk and derives its own 1 us tick.

---
 rtl/esc_output_controller.sv | 229 ++++++++++++++++++++++
 tb/tb_esc_output_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/esc_output_controller.sv
`default_nettype none
// ============================================================================
//  Module      : esc_output_controller
//  Description : N-channel ESC pulse generator with arming sequence, per-frame
//                slew limiting and a stale-data failsafe. A free-running 1 us
//                tick is derived from sys_clk. A frame counter in microseconds
//                sets the PWM frame. Each channel's pulse width follows its
//                applied rate. The applied rate changes only at frame wrap.
//
//  Ports       : sys_clk       - system clock
//                reset         - synchronous, active-high reset
//                motor_rate_in - packed rates, motor k at [k*RATE_WIDTH +: RATE_WIDTH]
//                rate_valid    - one-cycle strobe, captures motor_rate_in
//                arm_req       - level; 1 requests arming, 0 disarms at once
//                motor_pwm     - registered ESC pulse per motor
//                state         - 0 DISARMED, 1 ARMING, 2 ARMED, 3 FAILSAFE
//                failsafe      - high while in FAILSAFE
//                frame_start   - one-cycle pulse when the frame counter wraps
//
//  Revision    : 1.0 - initial release
// ============================================================================
module esc_output_controller #(
    parameter int NUM_MOTORS   = 4,
    parameter int RATE_WIDTH   = 8,
    parameter int RATE_MAX     = 250,
    parameter int CLKS_PER_US  = 38,
    parameter int PERIOD_US    = 2500,
    parameter int MIN_PULSE_US = 1000,
    parameter int US_PER_COUNT = 4,
    parameter int SLEW_STEP    = 25,
    parameter int ARM_FRAMES   = 200,
    parameter int TIMEOUT_US   = 50000
) (
    input  logic                             sys_clk,
    input  logic                             reset,
    input  logic [NUM_MOTORS*RATE_WIDTH-1:0] motor_rate_in,
    input  logic                             rate_valid,
    input  logic                             arm_req,
    output logic [NUM_MOTORS-1:0]            motor_pwm,
    output logic [1:0]                       state,
    output logic                             failsafe,
    output logic                             frame_start
);

    // ------------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------------
    localparam int PS_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam int FC_W = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    // Pulse width is one bit wider than the frame counter so the compare
    // cannot wrap.
    localparam int PW_W = FC_W + 1;
    localparam int AC_W = ($clog2(ARM_FRAMES + 1) > 0) ? $clog2(ARM_FRAMES + 1) : 1;
    localparam int TO_W = ($clog2(TIMEOUT_US + 1) > 0) ? $clog2(TIMEOUT_US + 1) : 1;
    localparam int RW1  = RATE_WIDTH + 1;

    localparam logic [PS_W-1:0]       C_PS_LAST  = PS_W'(CLKS_PER_US - 1);
    localparam logic [FC_W-1:0]       C_FC_LAST  = FC_W'(PERIOD_US - 1);
    localparam logic [RATE_WIDTH-1:0] C_RATE_MAX = RATE_WIDTH'(RATE_MAX);
    // A step at or above RATE_MAX always reaches the target in one frame.
    // Saturating the step here keeps it representable in the rate width.
    localparam logic [RW1-1:0]        C_SLEW     =
        RW1'((SLEW_STEP > RATE_MAX) ? RATE_MAX : SLEW_STEP);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ARMED    = 2'd2,
        ST_FAILSAFE = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Timebase: 1 us tick and frame counter
    // ------------------------------------------------------------------------
    logic [PS_W-1:0] r_presc;
    logic [FC_W-1:0] r_fcnt;
    logic            r_frame_start;
    logic            w_tick;
    logic            w_wrap;

    assign w_tick = (r_presc == C_PS_LAST);
    assign w_wrap = w_tick && (r_fcnt == C_FC_LAST);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_presc       <= '0;
            r_fcnt        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
            if (w_tick) begin
                r_fcnt <= w_wrap ? '0 : r_fcnt + FC_W'(1);
            end
            r_frame_start <= w_wrap;
        end
    end

    // ------------------------------------------------------------------------
    // Arming / failsafe state machine
    // ------------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_failsafe;
    logic [AC_W-1:0] r_arm_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_arm_done;
    logic            w_to_expire;

    // The current wrap is the last ARMING frame once the frames counted so
    // far, plus this one, reach ARM_FRAMES.
    assign w_arm_done  = (int'(r_arm_cnt) + 1) >= ARM_FRAMES;
    // Expiry happens on the tick that brings the stale counter to TIMEOUT_US.
    assign w_to_expire = w_tick && ((int'(r_to_cnt) + 1) >= TIMEOUT_US);

    always_comb begin
        w_state_nxt = r_state;
        if (!arm_req) begin
            // Disarm overrides every other transition.
            w_state_nxt = ST_DISARMED;
        end else begin
            case (r_state)
                ST_DISARMED: if (w_wrap) w_state_nxt = ST_ARMING;
                ST_ARMING:   if (w_wrap && w_arm_done) w_state_nxt = ST_ARMED;
                // A strobe in the expiry cycle counts as fresh data.
                ST_ARMED:    if (!rate_valid && w_to_expire) w_state_nxt = ST_FAILSAFE;
                default:     w_state_nxt = r_state;  // FAILSAFE is sticky
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state    <= ST_DISARMED;
            r_failsafe <= 1'b0;
            r_arm_cnt  <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_failsafe <= (w_state_nxt == ST_FAILSAFE);

            // Count the ARMING frames. The wrap that enters ARMING is not
            // counted.
            if (w_state_nxt != ST_ARMING) begin
                r_arm_cnt <= '0;
            end else if (w_wrap && (r_state == ST_ARMING)) begin
                r_arm_cnt <= r_arm_cnt + AC_W'(1);
            end

            // Stale-data counter. It is restarted on ARMED entry so that time
            // spent arming is not counted. It saturates while idle.
            if (rate_valid || ((r_state == ST_ARMING) && (w_state_nxt == ST_ARMED))) begin
                r_to_cnt <= '0;
            end else if (w_tick && (int'(r_to_cnt) < TIMEOUT_US)) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel target capture, slew limiter and pulse output
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_MOTORS; k++) begin : g_ch
        logic [RATE_WIDTH-1:0] r_tgt;
        logic [RATE_WIDTH-1:0] r_app;
        logic                  r_pwm;
        logic [RATE_WIDTH-1:0] w_rate_in;
        logic [RATE_WIDTH-1:0] w_rate_clamped;
        logic [RATE_WIDTH-1:0] w_slew_tgt;
        logic [RATE_WIDTH-1:0] w_delta;
        logic [RATE_WIDTH-1:0] w_app_nxt;
        logic [PW_W-1:0]       w_pulse;

        assign w_rate_in      = motor_rate_in[k*RATE_WIDTH +: RATE_WIDTH];
        assign w_rate_clamped = (w_rate_in > C_RATE_MAX) ? C_RATE_MAX : w_rate_in;

        // FAILSAFE ramps every channel down toward the minimum pulse.
        assign w_slew_tgt = (r_state == ST_FAILSAFE) ? '0 : r_tgt;
        assign w_delta    = (w_slew_tgt >= r_app) ? (w_slew_tgt - r_app)
                                                  : (r_app - w_slew_tgt);

        always_comb begin
            w_app_nxt = w_slew_tgt;
            if ((SLEW_STEP != 0) && ({1'b0, w_delta} > C_SLEW)) begin
                if (w_slew_tgt > r_app) begin
                    w_app_nxt = r_app + C_SLEW[RATE_WIDTH-1:0];
                end else begin
                    w_app_nxt = r_app - C_SLEW[RATE_WIDTH-1:0];
                end
            end
        end

        assign w_pulse = PW_W'(MIN_PULSE_US) + PW_W'(r_app) * PW_W'(US_PER_COUNT);

        always_ff @(posedge sys_clk) begin
            if (reset) begin
                r_tgt <= '0;
                r_app <= '0;
                r_pwm <= 1'b0;
            end else begin
                if (rate_valid) begin
                    r_tgt <= w_rate_clamped;
                end
                // A strobe in the wrap cycle is only seen by the next frame.
                // Nonblocking update gives that ordering.
                if (w_wrap) begin
                    if ((r_state == ST_DISARMED) || (r_state == ST_ARMING)) begin
                        r_app <= '0;
                    end else begin
                        r_app <= w_app_nxt;
                    end
                end
                // arm_req is included so a disarm kills the pulse on the
                // same edge that leaves the armed states.
                r_pwm <= arm_req && (r_state != ST_DISARMED) && ({1'b0, r_fcnt} < w_pulse);
            end
        end

        assign motor_pwm[k] = r_pwm;
    end : g_ch

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign state       = r_state;
    assign failsafe    = r_failsafe;
    assign frame_start = r_frame_start;

endmodule : esc_output_controller
`default_nettype wire

// File: tb/tb_esc_output_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_esc_output_controller
//  Description : Scoreboard bench for esc_output_controller. The parameters
//                are scaled so that one frame is 240 cycles. Settings:
//                2 clk/us, 120 us frame, 20 us min pulse, 4 us/count,
//                RATE_MAX 20, slew 5, 3 arm frames, 600 us timeout.
//                The stimulus pushes the expected state, failsafe and
//                per-motor pulse length (in cycles) for each frame it
//                describes. A monitor measures each frame and pops and
//                compares at the end of that frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_esc_output_controller;

    localparam int NM        = 4;
    localparam int RW        = 8;
    localparam int CPU       = 2;
    localparam int PER       = 120;
    localparam int FRAME_CYC = CPU * PER;

    logic            clk        = 1'b0;
    logic            reset      = 1'b1;
    logic [NM*RW-1:0] rate      = '0;
    logic            rate_valid = 1'b0;
    logic            arm_req    = 1'b0;
    logic [NM-1:0]   pwm;
    logic [1:0]      dut_state;
    logic            fs;
    logic            fstart;

    always #5 clk = ~clk;

    esc_output_controller #(
        .NUM_MOTORS  (NM),
        .RATE_WIDTH  (RW),
        .RATE_MAX    (20),
        .CLKS_PER_US (CPU),
        .PERIOD_US   (PER),
        .MIN_PULSE_US(20),
        .US_PER_COUNT(4),
        .SLEW_STEP   (5),
        .ARM_FRAMES  (3),
        .TIMEOUT_US  (600)
    ) dut (
        .sys_clk      (clk),
        .reset        (reset),
        .motor_rate_in(rate),
        .rate_valid   (rate_valid),
        .arm_req      (arm_req),
        .motor_pwm    (pwm),
        .state        (dut_state),
        .failsafe     (fs),
        .frame_start  (fstart)
    );

    typedef struct packed {
        logic [1:0]       st;
        logic             fs;
        logic [3:0][15:0] w;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic push(input int s, input int f, input int w0, input int w1,
                        input int w2, input int w3);
        exp_t e;
        e.st   = 2'(s);
        e.fs   = 1'(f);
        e.w[0] = 16'(w0);
        e.w[1] = 16'(w1);
        e.w[2] = 16'(w2);
        e.w[3] = 16'(w3);
        exp_q.push_back(e);
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fstart && n < 2 * FRAME_CYC);
        if (!fstart) check("frame_start_timeout", 0, 1);
    endtask

    // Wait for the next frame and record what that frame must look like.
    task automatic frame(input int s, input int f, input int w0, input int w1,
                         input int w2, input int w3);
        wait_fs();
        push(s, f, w0, w1, w2, w3);
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input int r0, input int r1, input int r2, input int r3);
        rate       = {8'(r3), 8'(r2), 8'(r1), 8'(r0)};
        rate_valid = 1'b1;
        @(negedge clk);
        rate_valid = 1'b0;
    endtask

    // Monitor: a frame starts on a sampled frame_start. It counts the high
    // cycles of every motor over FRAME_CYC cycles. It pops the expectation on
    // the last cycle of the frame, then checks that the next frame_start
    // follows immediately.
    initial begin : monitor
        exp_t             e;
        logic [3:0][15:0] w;
        logic [1:0]       s;
        logic             f;
        @(negedge clk);
        forever begin
            if (fstart && !reset) begin
                s = dut_state;
                f = fs;
                w = '0;
                for (int i = 0; i < FRAME_CYC; i++) begin
                    if (i > 0) @(negedge clk);
                    for (int k = 0; k < NM; k++) w[k] = w[k] + 16'(pwm[k]);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (e.st != s || e.fs != f || e.w != w) begin
                        errors++;
                        $display("FAIL frame_rec: got st=%0d fs=%0d w=%0d,%0d,%0d,%0d want st=%0d fs=%0d w=%0d,%0d,%0d,%0d",
                                 s, f, w[0], w[1], w[2], w[3],
                                 e.st, e.fs, e.w[0], e.w[1], e.w[2], e.w[3]);
                    end
                end
                @(negedge clk);
                if (mon_en) check("frame_period", int'(fstart), 1);
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin : watchdog
        #(30000 * 10);
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        // ---------------- reset / idle ----------------
        reset   = 1'b1;
        arm_req = 1'b0;
        skip(5);
        check("rst_pwm", int'(pwm), 0);
        check("rst_state", int'(dut_state), 0);
        check("rst_failsafe", int'(fs), 0);
        check("rst_frame_start", int'(fstart), 0);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fstart && n < 1000);
        check("first_frame_latency", n, FRAME_CYC);
        push(0, 0, 0, 0, 0, 0);
        frame(0, 0, 0, 0, 0, 0);
        skip(10);
        arm_req = 1'b1;

        // ---------------- arming: 3 frames of min pulse ----------------
        frame(1, 0, 40, 40, 40, 40);
        frame(1, 0, 40, 40, 40, 40);
        skip(10);
        strobe(20, 255, 10, 0);        // targets {20,20,10,0} (255 clamps)
        frame(1, 0, 40, 40, 40, 40);

        // ---------------- armed: slew 5 counts per frame ----------------
        frame(2, 0, 40, 40, 40, 40);
        frame(2, 0, 80, 80, 80, 40);
        frame(2, 0, 120, 120, 120, 40);
        frame(2, 0, 160, 160, 120, 40);
        frame(2, 0, 200, 200, 120, 40);
        // Strobe in the wrap cycle. It is also the cycle where the timeout
        // would expire. The new targets must wait one frame.
        skip(239);
        strobe(0, 20, 20, 8);
        check("collision1_state", int'(dut_state), 2);
        check("collision1_failsafe", int'(fs), 0);
        push(2, 0, 200, 200, 120, 40);
        frame(2, 0, 160, 200, 160, 80);
        frame(2, 0, 120, 200, 200, 104);
        frame(2, 0, 80, 200, 200, 104);
        frame(2, 0, 40, 200, 200, 104);
        skip(239);
        check("pre_timeout_state", int'(dut_state), 2);

        // ---------------- failsafe after 600 silent ticks ----------------
        frame(3, 1, 40, 200, 200, 104);
        frame(3, 1, 40, 160, 160, 64);
        skip(10);
        strobe(20, 20, 20, 20);        // must not leave FAILSAFE
        frame(3, 1, 40, 120, 120, 40);
        frame(3, 1, 40, 80, 80, 40);
        frame(3, 1, 40, 40, 40, 40);
        skip(100);
        arm_req = 1'b0;
        skip(1);
        check("disarm_state", int'(dut_state), 0);
        check("disarm_failsafe", int'(fs), 0);

        // ---------------- re-arm, timeout collision, mid-pulse disarm -------
        frame(0, 0, 0, 0, 0, 0);
        skip(10);
        arm_req = 1'b1;
        frame(1, 0, 40, 40, 40, 40);
        skip(10);
        strobe(12, 12, 12, 12);
        frame(1, 0, 40, 40, 40, 40);
        frame(1, 0, 40, 40, 40, 40);
        frame(2, 0, 40, 40, 40, 40);
        frame(2, 0, 80, 80, 80, 80);
        frame(2, 0, 120, 120, 120, 120);
        frame(2, 0, 136, 136, 136, 136);
        frame(2, 0, 136, 136, 136, 136);
        skip(239);
        strobe(12, 12, 12, 12);        // lands on the expiry tick
        check("collision2_state", int'(dut_state), 2);
        check("collision2_failsafe", int'(fs), 0);
        push(2, 0, 60, 60, 60, 60);    // 136-cycle pulse cut at cycle 60
        skip(60);
        arm_req = 1'b0;
        skip(1);
        check("disarm_pwm", int'(pwm), 0);
        check("disarm_mid_state", int'(dut_state), 0);
        arm_req = 1'b1;

        // ---------------- reset mid-pulse ----------------
        wait_fs();
        mon_en = 1'b0;
        skip(20);
        check("pre_reset_pwm", int'(pwm), 15);
        reset = 1'b1;
        skip(1);
        check("reset_pwm", int'(pwm), 0);
        check("reset_state", int'(dut_state), 0);
        check("reset_failsafe", int'(fs), 0);
        check("reset_frame_start", int'(fstart), 0);
        skip(3);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fstart && n < 1000);
        check("reset_frame_latency", n, FRAME_CYC);
        check("rearm_after_reset", int'(dut_state), 1);
        skip(20);
        check("rearm_min_pulse", int'(pwm), 15);

        check("scoreboard_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_esc_output_controller
`default_nettype wire
